// File: rtl/my_mem_req_ctrl.sv
`timescale 1ns/1ps
// my_mem_req_ctrl
//   Request front-end for the 4x10 chip-select memory array top. Takes one
//   read/write request at a time, decodes the global address
//   {bank[BW-1:0], local[AW-1:0]} into a one-hot top_csel plus a local address,
//   runs a fixed-length write pulse or a fixed-latency read, and returns a
//   response (read data or write ack, plus error flag).
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_we/req_addr/req_wdata request fields (1 = write)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_err         read data (0 for writes/errors), bad-bank flag
//   top_csel/mem_we           one-hot chip select, write strobe (registered)
//   w_addr/w_data/r_addr      array write address/data, read address (registered)
//   r_data                    array read data
module my_mem_req_ctrl #(
   parameter int unsigned NUM_CS = 40,
   parameter int unsigned AW     = 12,
   parameter int unsigned DW     = 32,
   parameter int unsigned BW     = 6,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned WR_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [BW+AW-1:0]  req_addr,
   input  logic [DW-1:0]     req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err,
   output logic [NUM_CS-1:0] top_csel,
   output logic              mem_we,
   output logic [AW-1:0]     w_addr,
   output logic [DW-1:0]     w_data,
   output logic [AW-1:0]     r_addr,
   input  logic [DW-1:0]     r_data
);

   localparam int unsigned MAX_CYC = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);
   // One extra bit so NUM_CS up to 2**BW compares correctly.
   localparam logic [BW:0] NUM_CS_EXT = (BW+1)'(NUM_CS);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic [NUM_CS-1:0] top_csel_q, top_csel_d;
   logic              mem_we_q, mem_we_d;
   logic [AW-1:0]     w_addr_q, w_addr_d;
   logic [DW-1:0]     w_data_q, w_data_d;
   logic [AW-1:0]     r_addr_q, r_addr_d;

   logic [BW-1:0]     bank;
   logic [AW-1:0]     loc;
   logic              bank_err;
   logic [NUM_CS-1:0] csel_dec;

   assign bank     = req_addr[BW+AW-1:AW];
   assign loc      = req_addr[AW-1:0];
   assign bank_err = ({1'b0, bank} >= NUM_CS_EXT);
   assign csel_dec = NUM_CS'(1) << bank;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      top_csel_d  = top_csel_q;
      mem_we_d    = mem_we_q;
      w_addr_d    = w_addr_q;
      w_data_d    = w_data_q;
      r_addr_d    = r_addr_q;

      case (state_q)
         IDLE: begin
            // req_ready is a flop so it stays low through reset and rises
            // on the first edge after release.
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               if (bank_err) begin
                  state_d     = RESP;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
               end else if (req_we) begin
                  state_d    = WRITE;
                  cnt_d      = WR_LOAD;
                  top_csel_d = csel_dec;
                  mem_we_d   = 1'b1;
                  w_addr_d   = loc;
                  w_data_d   = req_wdata;
               end else begin
                  state_d    = READ;
                  cnt_d      = RD_LOAD;
                  top_csel_d = csel_dec;
                  r_addr_d   = loc;
               end
            end
         end
         WRITE: begin
            if (cnt_q == '0) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               top_csel_d  = '0;
               mem_we_d    = 1'b0;
               w_addr_d    = '0;
               w_data_d    = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         READ: begin
            // Sample r_data at the end of the last held cycle.
            if (cnt_q == '0) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = r_data;
               top_csel_d  = '0;
               r_addr_d    = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b0;
            rsp_valid_d = 1'b0;
            top_csel_d  = '0;
            mem_we_d    = 1'b0;
            w_addr_d    = '0;
            w_data_d    = '0;
            r_addr_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         top_csel_q  <= '0;
         mem_we_q    <= 1'b0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         r_addr_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         top_csel_q  <= top_csel_d;
         mem_we_q    <= mem_we_d;
         w_addr_q    <= w_addr_d;
         w_data_q    <= w_data_d;
         r_addr_q    <= r_addr_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign top_csel  = top_csel_q;
   assign mem_we    = mem_we_q;
   assign w_addr    = w_addr_q;
   assign w_data    = w_data_q;
   assign r_addr    = r_addr_q;

endmodule

// File: tb/tb_my_mem_req_ctrl.sv
`timescale 1ns/1ps
// Directed bench for my_mem_req_ctrl with a behavioural chip-select array
// and an address-keyed scoreboard of expected memory contents.
module tb_my_mem_req_ctrl;
   localparam int unsigned NUM_CS = 40;
   localparam int unsigned AW     = 12;
   localparam int unsigned DW     = 32;
   localparam int unsigned BW     = 6;
   localparam int unsigned RD_LAT = 3;
   localparam int unsigned WR_CYC = 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [BW+AW-1:0]  req_addr = '0;
   logic [DW-1:0]     req_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic [NUM_CS-1:0] top_csel;
   logic              mem_we;
   logic [AW-1:0]     w_addr;
   logic [DW-1:0]     w_data;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_data = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   my_mem_req_ctrl #(
      .NUM_CS(NUM_CS), .AW(AW), .DW(DW), .BW(BW), .RD_LAT(RD_LAT), .WR_CYC(WR_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .top_csel(top_csel), .mem_we(mem_we),
      .w_addr(w_addr), .w_data(w_data), .r_addr(r_addr), .r_data(r_data)
   );

   // Array model keyed by chip index * 4096 + local address; preload backdoor.
   logic [DW-1:0] arr [int];
   logic          pl_en  = 1'b0;
   int            pl_key = 0;
   logic [DW-1:0] pl_val = '0;

   always @(posedge clk) begin
      if (pl_en) arr[pl_key] = pl_val;
      if (mem_we)
         for (int unsigned i = 0; i < NUM_CS; i++)
            if (top_csel[i]) arr[int'(i) * 4096 + int'(w_addr)] = w_data;
   end

   // Read data presented mid-cycle from the currently selected chip.
   always @(negedge clk) begin
      logic [DW-1:0] v;
      int            k;
      v = '0;
      for (int unsigned i = 0; i < NUM_CS; i++)
         if (top_csel[i]) begin
            k = int'(i) * 4096 + int'(r_addr);
            if (arr.exists(k)) v = arr[k];
         end
      r_data = v;
   end

   // Per-cycle invariants and handshake counting.
   logic mon_en = 1'b0;
   logic cnt_en = 1'b0;
   int   acc_cnt = 0;
   int   rsp_cnt = 0;

   always @(negedge clk) begin
      logic ok;
      if (mon_en) begin
         ok = ($countones(top_csel) <= 1) &&
              (!mem_we || $countones(top_csel) == 1) &&
              (!mem_we || r_addr == '0) &&
              (mem_we || (w_addr == '0 && w_data == '0));
         checks++;
         assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL invariant: observed csel=%0h we=%0b waddr=%0h wdata=%0h raddr=%0h required one-hot/clean",
                   top_csel, mem_we, w_addr, w_data, r_addr);
         end
      end
      if (cnt_en && rst) begin
         if (req_valid && req_ready) acc_cnt++;
         if (rsp_valid && rsp_ready) rsp_cnt++;
      end
   end

   logic [DW-1:0] sb [int];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [BW+AW-1:0] addr, input logic [DW-1:0] wd);
      int n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("req_ready_wait", req_ready, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      tick();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("rsp_wait", rsp_valid, 1);
   endtask

   task automatic preload(input int key, input logic [DW-1:0] val);
      pl_en  = 1'b1;
      pl_key = key;
      pl_val = val;
      tick();
      pl_en  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      mon_en = 1'b1;
      tick();
      tick();
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_csel", top_csel, 0);
      check("rst_rdata", rsp_rdata, 0);
      rst = 1'b1;
      tick();
      check("ready_after_rst", req_ready, 1);

      // Reset during a read, second held cycle
      issue(1'b0, {6'd5, 12'h010}, '0);
      check("abort_csel_c1", top_csel, 40'h20);
      tick();
      check("abort_csel_c2", top_csel, 40'h20);
      #2 rst = 1'b0;
      #1;
      check("abort_csel_now", top_csel, 0);
      check("abort_rsp_now", rsp_valid, 0);
      tick();
      rst = 1'b1;
      tick();
      check("abort_ready", req_ready, 1);
      for (int i = 0; i < 4; i++) begin
         check("abort_no_rsp", rsp_valid, 0);
         tick();
      end
      cnt_en = 1'b1;

      // Write 005A3 <- DEADBEEF
      issue(1'b1, 18'h005A3, 32'hDEADBEEF);
      sb[int'(18'h005A3)] = 32'hDEADBEEF;
      check("wr_csel", top_csel, 40'h1);
      check("wr_we", mem_we, 1);
      check("wr_waddr", w_addr, 12'h5A3);
      check("wr_wdata", w_data, 32'hDEADBEEF);
      check("wr_raddr", r_addr, 0);
      check("wr_no_rsp", rsp_valid, 0);
      tick();
      check("wr_csel_off", top_csel, 0);
      check("wr_we_off", mem_we, 0);
      check("wr_rsp_valid", rsp_valid, 1);
      check("wr_rsp_err", rsp_err, 0);
      check("wr_rsp_rdata", rsp_rdata, 0);
      tick();
      check("wr_done_valid", rsp_valid, 0);
      check("wr_done_ready", req_ready, 1);

      // Read 27FFF (bank 39)
      preload(39 * 4096 + 'hFFF, 32'h12345678);
      sb[int'(18'h27FFF)] = 32'h12345678;
      issue(1'b0, 18'h27FFF, '0);
      for (int i = 0; i < int'(RD_LAT); i++) begin
         check("rd_csel", top_csel, 40'h80_0000_0000);
         check("rd_raddr", r_addr, 12'hFFF);
         check("rd_we", mem_we, 0);
         check("rd_no_rsp", rsp_valid, 0);
         tick();
      end
      check("rd_rsp_valid", rsp_valid, 1);
      check("rd_rdata", rsp_rdata, 32'h12345678);
      check("rd_err", rsp_err, 0);
      check("rd_csel_off", top_csel, 0);
      check("rd_raddr_off", r_addr, 0);
      tick();
      check("rd_done_ready", req_ready, 1);

      // Read 28000 (bank 40, out of range)
      issue(1'b0, 18'h28000, '0);
      check("err_rsp_valid", rsp_valid, 1);
      check("err_flag", rsp_err, 1);
      check("err_rdata", rsp_rdata, 0);
      check("err_csel", top_csel, 0);
      tick();
      check("err_done_valid", rsp_valid, 0);

      // Response back-pressure
      preload(10 * 4096 + 'h123, 32'hCAFEF00D);
      sb[int'(18'h0A123)] = 32'hCAFEF00D;
      rsp_ready = 1'b0;
      issue(1'b0, 18'h0A123, '0);
      for (int i = 0; i < int'(RD_LAT); i++) tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", rsp_valid, 1);
         check("bp_rdata", rsp_rdata, 32'hCAFEF00D);
         check("bp_ready", req_ready, 0);
         check("bp_csel", top_csel, 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_release_valid", rsp_valid, 0);
      check("bp_release_ready", req_ready, 1);

      // Random back-to-back traffic on a small address pool
      for (int n = 0; n < 20; n++) begin
         int unsigned     r;
         logic            we;
         logic [BW-1:0]   bank;
         logic [AW-1:0]   loc;
         logic [DW-1:0]   wd;
         logic [DW-1:0]   exp_rd;
         logic            exp_err;
         logic [BW+AW-1:0] a;
         r    = $urandom_range(0, 4);
         bank = (r == 4) ? 6'd41 : 6'(r * 13);
         loc  = 12'($urandom_range(0, 3));
         we   = 1'($urandom_range(0, 1));
         wd   = $urandom;
         a    = {bank, loc};
         exp_err = (bank >= 6'd40);
         exp_rd  = '0;
         if (!we && !exp_err && sb.exists(int'(a))) exp_rd = sb[int'(a)];
         if (we && !exp_err) sb[int'(a)] = wd;
         issue(we, a, wd);
         wait_rsp();
         check("rnd_err", rsp_err, exp_err);
         check("rnd_rdata", rsp_rdata, exp_rd);
         tick();
      end

      tick();
      check("acc_count", acc_cnt, 24);
      check("rsp_count", rsp_cnt, acc_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
